// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state type and default parameters for the serial pattern detector
package seq_detect_pkg;

   typedef enum logic {SEARCH, HIT} state_t;

   localparam int         DEF_PAT_W         = 4;
   localparam logic [3:0] DEF_RESET_PATTERN = 4'b1010;
   localparam int         DEF_CNT_W         = 8;

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// seq_detect_sat_cnt: saturating up-counter, clear beats increment
module seq_detect_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // count up on inc, stick at all-ones, clear on reset or clr
   always_ff @(posedge clk) begin
      if (!rst_n || clr) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: Moore serial pattern detector with reloadable pattern and match counter
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int               PAT_W         = DEF_PAT_W,
   parameter logic [PAT_W-1:0] RESET_PATTERN = DEF_RESET_PATTERN,
   parameter int               CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             overlap_en,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int             FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FULL = FW'(PAT_W);

   logic [PAT_W-1:0] pattern_q, pattern_nx, hist, hist_nx, hist_sh;
   logic [FW-1:0]    fill, fill_nx, fill_inc;
   state_t           state, state_nx;
   logic             hit;

   // next-state: a load wipes history, an accepted bit shifts in and may hit;
   // fill gates the comparator so cleared zeros in hist never match
   always_comb begin
      hist_sh    = {hist[PAT_W-2:0], din};
      fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
      hit        = din_valid && !pat_load && fill_inc == FULL && hist_sh == pattern_q;
      pattern_nx = pat_load ? pat_in : pattern_q;
      hist_nx    = pat_load ? '0 : din_valid ? hist_sh : hist;
      fill_nx    = pat_load ? '0 : !din_valid ? fill : (hit && !overlap_en) ? '0 : fill_inc;
      state_nx   = pat_load ? SEARCH : !din_valid ? state : hit ? HIT : SEARCH;
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pattern_q <= RESET_PATTERN;
         hist      <= '0;
         fill      <= '0;
         state     <= SEARCH;
      end else begin
         pattern_q <= pattern_nx;
         hist      <= hist_nx;
         fill      <= fill_nx;
         state     <= state_nx;
      end
   end

   assign match = (state == HIT);

   seq_detect_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit),
      .clr   (cnt_clr),
      .cnt   (match_cnt)
   );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random stimulus checked against a bit-queue reference model
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       overlap_en = 1'b1;
   logic       pat_load = 1'b0;
   logic [3:0] pat_in = 4'b0;
   logic       cnt_clr = 1'b0;
   logic       match, match_c2;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt_c2;

   int checks = 0;
   int errors = 0;

   // reference model: accepted bits since the last reset/load/non-overlap hit
   bit         win[$];
   logic [3:0] m_pat = 4'b1010;
   logic       m_match = 1'b0;
   int         m_cnt8 = 0;
   int         m_cnt2 = 0;

   always #5 clk = ~clk;

   seq_detect_param dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt)
   );

   seq_detect_param #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .match(match_c2), .match_cnt(match_cnt_c2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit hit = 0;
      logic [3:0] v = '0;
      if (!rst_n) begin
         m_pat = 4'b1010; win.delete(); m_match = 0; m_cnt8 = 0; m_cnt2 = 0;
         return;
      end
      if (pat_load) begin
         m_pat = pat_in; win.delete(); m_match = 0;
      end else if (din_valid) begin
         win.push_back(din);
         if (win.size() >= 4) begin
            for (int i = 0; i < 4; i++) v = {v[2:0], win[win.size() - 4 + i]};
            hit = (v == m_pat);
         end
         m_match = hit;
         if (hit && !overlap_en) win.delete();
         while (win.size() > 4) void'(win.pop_front());
      end
      if (cnt_clr) begin
         m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
         m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
         m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
   endtask

   task automatic step(input string tag, input logic r, input logic dv, input logic d,
                       input logic pl, input logic [3:0] pi, input logic cc);
      rst_n = r; din_valid = dv; din = d; pat_load = pl; pat_in = pi; cnt_clr = cc;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, "_match"}, match, m_match);
      chk({tag, "_cnt"}, match_cnt, m_cnt8);
      chk({tag, "_match_c2"}, match_c2, m_match);
      chk({tag, "_cnt_c2"}, match_cnt_c2, m_cnt2);
   endtask

   task automatic bits(input string tag, input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(tag, 1, 1, v[i], 0, 4'h0, 0);
   endtask

   task automatic do_reset();
      step("rst", 0, 0, 0, 0, 4'h0, 0);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      do_reset();
      chk("reset_match", match, 0);
      chk("reset_cnt", match_cnt, 0);

      overlap_en = 1;
      bits("ovl", 16'b101010, 6);
      chk("ovl_total", match_cnt, 2);

      do_reset();
      overlap_en = 0;
      bits("novl", 16'b101010, 6);
      chk("novl_total", match_cnt, 1);
      chk("novl_last", match, 0);

      do_reset();
      overlap_en = 1;
      bits("gap", 16'b101, 3);
      repeat (3) step("gap_idle", 1, 0, 1, 0, 4'h0, 0);
      bits("gap", 16'b0, 1);
      chk("gap_hit", match, 1);
      repeat (2) step("gap_hold", 1, 0, 0, 0, 4'h0, 0);
      chk("gap_hold_level", match, 1);

      bits("load_pre", 16'b10, 2);
      step("load", 1, 1, 1, 1, 4'b1101, 0);
      bits("load_old", 16'b1010, 4);
      bits("load_new", 16'b1101, 4);
      chk("load_hit", match, 1);

      do_reset();
      overlap_en = 1;
      bits("sat", 16'b1010101010, 10);
      chk("sat_c2", match_cnt_c2, 3);
      chk("sat_c8", match_cnt, 4);
      step("clr_pre", 1, 1, 1, 0, 4'h0, 0);
      step("clr_hit", 1, 1, 0, 0, 4'h0, 1);
      chk("clr_match", match, 1);
      chk("clr_c2", match_cnt_c2, 0);

      do_reset();
      bits("midrst", 16'b101, 3);
      do_reset();
      bits("midrst_post", 16'b0, 1);
      chk("midrst_match", match, 0);
      bits("midrst_pat", 16'b1010, 4);
      chk("midrst_revert", match, 1);

      for (int i = 0; i < 600; i++) begin
         overlap_en = ($urandom_range(0, 3) != 0);
         step("rand",
              ($urandom_range(0, 99) != 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 1) != 0) ? 4'b1010 : 4'($urandom),
              ($urandom_range(0, 29) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
